alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential integer ALU with a valid/ready request port and a valid/ready result port.
// Single-cycle basic ops; iterative one-bit-per-cycle multiply and divide.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] rv1,
  input  logic [WIDTH-1:0] rv2,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rvout
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SLL    = 5'd1,  OP_SLT    = 5'd2,  OP_SLTU  = 5'd3,
    OP_XOR  = 5'd4,  OP_SRL    = 5'd5,  OP_OR     = 5'd6,  OP_AND   = 5'd7,
    OP_SRA  = 5'd8,  OP_SUB    = 5'd9,  OP_MUL    = 5'd10, OP_MULH  = 5'd11,
    OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV   = 5'd14, OP_DIVU  = 5'd15,
    OP_REM  = 5'd16, OP_REMU   = 5'd17
  } op_e;

  localparam logic [SHW:0]     CNT_LAST = (SHW+1)'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_next;

  logic               accept, last;
  logic               is_mul, is_div, is_slow, sign1, sign2, div_zero, div_ovf;
  logic [WIDTH-1:0]   mag1, mag2, fast_result, slow_result;
  logic [SHW-1:0]     shamt;

  logic [2*WIDTH-1:0] acc, step, prod;
  logic [WIDTH-1:0]   opnd;
  logic [4:0]         op_q;
  logic               neg_q, neg_r;
  logic [SHW:0]       cnt;
  logic               mul_q;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;

  assign in_ready  = (state == IDLE) && reset;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (state == BUSY) && (cnt == CNT_LAST);
  assign shamt     = rv2[SHW-1:0];

  // Request decode and the complete result for everything that finishes in one cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fast_result = '0;
    is_mul   = (op >= OP_MUL) && (op <= OP_MULHU);
    is_div   = (op >= OP_DIV) && (op <= OP_REMU);
    div_zero = (rv2 == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (rv1 == MOST_NEG) && (rv2 == '1);
    is_slow  = is_mul || (is_div && !div_zero && !div_ovf);
    sign1    = rv1[WIDTH-1] &&
               ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM));
    sign2    = rv2[WIDTH-1] && ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
    mag1     = sign1 ? -rv1 : rv1;
    mag2     = sign2 ? -rv2 : rv2;

    case (op)
      OP_ADD:  fast_result = rv1 + rv2;
      OP_SLL:  fast_result = rv1 << shamt;
      OP_SLT:  fast_result = {{(WIDTH-1){1'b0}}, $signed(rv1) < $signed(rv2)};
      OP_SLTU: fast_result = {{(WIDTH-1){1'b0}}, rv1 < rv2};
      OP_XOR:  fast_result = rv1 ^ rv2;
      OP_SRL:  fast_result = rv1 >> shamt;
      OP_OR:   fast_result = rv1 | rv2;
      OP_AND:  fast_result = rv1 & rv2;
      OP_SRA:  fast_result = $signed(rv1) >>> shamt;
      OP_SUB:  fast_result = rv1 - rv2;
      OP_DIV, OP_DIVU: fast_result = div_zero ? '1 : rv1;
      OP_REM, OP_REMU: fast_result = div_zero ? rv1 : '0;
      default: fast_result = '0;
    endcase
  end

  // One iteration: shift-add multiply on {hi,lo}, or restoring divide with hi = remainder.
  always_comb begin
    mul_q     = (op_q >= OP_MUL) && (op_q <= OP_MULHU);
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    step      = '0;
    if (mul_q)
      step = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    else if (div_diff[WIDTH])
      step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Magnitudes were iterated; restore signs on the final value.
    prod = neg_q ? -step : step;
    case (op_q)
      OP_MUL:                        slow_result = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  slow_result = prod[2*WIDTH-1:WIDTH];
      OP_DIV:  slow_result = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
      OP_DIVU: slow_result = step[WIDTH-1:0];
      OP_REM:  slow_result = neg_r ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
      OP_REMU: slow_result = step[2*WIDTH-1:WIDTH];
      default: slow_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = is_slow ? BUSY : DONE;
      BUSY:    if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, so an aborted operation leaves nothing visible.
    if (!reset) begin
      acc   <= '0;
      opnd  <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
      rvout <= '0;
    end else if (accept) begin
      op_q  <= op;
      cnt   <= '0;
      neg_q <= sign1 ^ sign2;
      neg_r <= sign1;
      if (is_mul) begin
        acc  <= {{WIDTH{1'b0}}, mag2};
        opnd <= mag1;
      end else begin
        acc  <= {{WIDTH{1'b0}}, mag1};
        opnd <= mag2;
      end
      if (!is_slow) rvout <= fast_result;
    end else if (state == BUSY) begin
      acc <= step;
      cnt <= cnt + 1'b1;
      if (last) rvout <= slow_result;
    end
  end

endmodule
